// File: rtl/hex_display_ctrl_if.sv
// Bus between switch/register logic and the 7-segment driver: load strobe,
// hex word, display controls, and the segment/tick outputs.
interface hex_display_ctrl_if #(
    parameter int unsigned NUM_DIGITS = 8
);
    logic                      load;
    logic [4*NUM_DIGITS-1:0]   value;
    logic [1:0]                mode;
    logic                      lz_blank;
    logic [7*NUM_DIGITS-1:0]   seg_out;
    logic                      tick;

    modport master (output load, value, mode, lz_blank, input seg_out, tick);
    modport slave  (input load, value, mode, lz_blank, output seg_out, tick);
endinterface

// File: rtl/hex_display_ctrl.sv
// Multi-digit active-low 7-segment driver with static, blink and scroll modes
// and optional leading-zero blanking; segment outputs are registered.
module hex_display_ctrl #(
    parameter int unsigned NUM_DIGITS = 8,
    parameter int unsigned TICK_DIV   = 12500000
) (
    input  logic                CLOCK_50,
    input  logic                reset,
    hex_display_ctrl_if.slave   dsp
);
    localparam int unsigned PW = $clog2(TICK_DIV);
    localparam int unsigned RW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    typedef enum logic [1:0] {
        ModeStatic = 2'b00,
        ModeBlink  = 2'b01,
        ModeScroll = 2'b10,
        ModeRsvd   = 2'b11
    } mode_e;

    mode_e                    mode;
    logic [4*NUM_DIGITS-1:0]  disp_q, disp_d;
    logic [RW-1:0]            rot_q, rot_d;
    logic                     phase_q, phase_d;
    logic [PW-1:0]            presc_q, presc_d;
    logic                     tick_q, tick_d;
    logic [7*NUM_DIGITS-1:0]  seg_q, seg_d;
    logic                     wrap;

    assign mode = mode_e'(dsp.mode);

    function automatic logic [6:0] decode(input logic [3:0] nib);
        logic [6:0] p;
        case (nib)
            4'h0: p = 7'h3F;  4'h1: p = 7'h06;  4'h2: p = 7'h5B;  4'h3: p = 7'h4F;
            4'h4: p = 7'h66;  4'h5: p = 7'h6D;  4'h6: p = 7'h7D;  4'h7: p = 7'h07;
            4'h8: p = 7'h7F;  4'h9: p = 7'h6F;  4'hA: p = 7'h77;  4'hB: p = 7'h7C;
            4'hC: p = 7'h39;  4'hD: p = 7'h5E;  4'hE: p = 7'h79;  default: p = 7'h71;
        endcase
        return p;
    endfunction

    always_comb begin
        wrap    = (presc_q == PW'(TICK_DIV - 1));
        disp_d  = disp_q;
        rot_d   = rot_q;
        phase_d = phase_q;
        presc_d = wrap ? '0 : presc_q + 1'b1;
        tick_d  = wrap;
        if (dsp.load) begin
            // Load restarts the timebase, so a coincident wrap is discarded.
            disp_d  = dsp.value;
            rot_d   = '0;
            phase_d = 1'b1;
            presc_d = '0;
            tick_d  = 1'b0;
        end else begin
            if (mode != ModeScroll) begin
                rot_d = '0;
            end else if (wrap) begin
                rot_d = (rot_q == RW'(NUM_DIGITS - 1)) ? '0 : rot_q + 1'b1;
            end
            if (mode != ModeBlink) begin
                phase_d = 1'b1;
            end else if (wrap) begin
                phase_d = ~phase_q;
            end
        end
    end

    always_comb begin
        logic       seen;
        logic       lz_en;
        logic       dark;
        logic [3:0] nib;
        int         src;
        seg_d = '1;
        seen  = 1'b0;
        nib   = '0;
        src   = 0;
        dark  = (mode == ModeBlink) && !phase_q;
        lz_en = dsp.lz_blank && (mode != ModeScroll);
        // Walk from the MSB so the first nonzero nibble stops the blanking.
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            if (mode == ModeScroll) begin
                src = (i + int'(NUM_DIGITS) - int'(rot_q)) % int'(NUM_DIGITS);
            end else begin
                src = i;
            end
            nib = disp_q[4*src +: 4];
            if (nib != 4'h0 || i == 0) seen = 1'b1;
            seg_d[7*i +: 7] = (dark || (lz_en && !seen)) ? 7'h7F : ~decode(nib);
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            disp_q  <= '0;
            rot_q   <= '0;
            phase_q <= 1'b1;
            presc_q <= '0;
            tick_q  <= 1'b0;
            seg_q   <= '1;
        end else begin
            disp_q  <= disp_d;
            rot_q   <= rot_d;
            phase_q <= phase_d;
            presc_q <= presc_d;
            tick_q  <= tick_d;
            seg_q   <= seg_d;
        end
    end

    assign dsp.seg_out = seg_q;
    assign dsp.tick    = tick_q;
endmodule

// File: tb/tb_hex_display_ctrl.sv
// Self-checking bench for hex_display_ctrl: vector table, corner sequences
// and randomized traffic against a word-level reference model.
module tb_hex_display_ctrl;
    localparam int unsigned ND = 8;
    localparam int unsigned TD = 4;

    logic clk = 1'b0;
    logic rst;

    hex_display_ctrl_if #(.NUM_DIGITS(ND)) dif ();

    hex_display_ctrl #(.NUM_DIGITS(ND), .TICK_DIV(TD)) dut (
        .CLOCK_50 (clk),
        .reset    (rst),
        .dsp      (dif)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [6:0] tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Reference model state
    logic [31:0] m_val = '0;
    int          m_rot = 0;
    int          m_cnt = 0;
    bit          m_ph  = 1'b1;
    logic [55:0] m_seg = '1;
    bit          m_tick = 1'b0;
    bit          model_on = 1'b1;

    typedef struct {
        logic [31:0]      value;
        logic [1:0]       mode;
        logic             lz;
        logic [7:0][7:0]  pat;  // active-high pattern per digit, digit 7 first
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [55:0] from_pat(input logic [7:0][7:0] pat);
        logic [55:0] s;
        for (int i = 0; i < 8; i++) s[7*i +: 7] = ~pat[i][6:0];
        return s;
    endfunction

    function automatic logic [55:0] model_disp(input logic [31:0] v, input int r, input bit ph,
                                               input logic [1:0] md, input bit lz);
        logic [31:0] w;
        logic [55:0] s;
        int          top;
        if (md == 2'b01 && !ph) return '1;
        w = (md == 2'b10 && r != 0) ? ((v << (4 * r)) | (v >> (32 - 4 * r))) : v;
        top = 0;
        for (int i = 0; i < 8; i++) if (v[4*i +: 4] != 4'h0) top = i;
        for (int i = 0; i < 8; i++) begin
            if (lz && md != 2'b10 && i > top) s[7*i +: 7] = 7'h7F;
            else s[7*i +: 7] = ~tab[w[4*i +: 4]];
        end
        return s;
    endfunction

    // One clock: predict from pre-edge state and inputs, advance model, compare.
    task automatic step();
        logic [55:0] nseg;
        bit          ntick;
        bit          wr;
        nseg  = rst ? '1 : model_disp(m_val, m_rot, m_ph, dif.mode, dif.lz_blank);
        ntick = !rst && !dif.load && (m_cnt == TD - 1);
        if (rst) begin
            m_val = '0; m_rot = 0; m_ph = 1'b1; m_cnt = 0;
        end else if (dif.load) begin
            m_val = dif.value; m_rot = 0; m_ph = 1'b1; m_cnt = 0;
        end else begin
            wr    = (m_cnt == TD - 1);
            m_cnt = (m_cnt + 1) % TD;
            if (dif.mode != 2'b10) m_rot = 0;
            else if (wr) m_rot = (m_rot + 1) % ND;
            if (dif.mode != 2'b01) m_ph = 1'b1;
            else if (wr) m_ph = !m_ph;
        end
        @(posedge clk);
        #1;
        m_seg  = nseg;
        m_tick = ntick;
        if (model_on) begin
            chk("model_seg", dif.seg_out, m_seg);
            chk("model_tick", dif.tick, m_tick);
        end
    endtask

    task automatic do_load(input logic [31:0] v, input logic [1:0] md, input logic lz);
        dif.value = v; dif.mode = md; dif.lz_blank = lz; dif.load = 1'b1;
        step();
        dif.load = 1'b0;
    endtask

    vec_t vecs [8];

    initial begin
        vecs[0] = '{32'h0123_ABCD, 2'b00, 1'b0, 64'h3F06_5B4F_777C_395E};
        vecs[1] = '{32'h0123_ABCD, 2'b00, 1'b1, 64'h0006_5B4F_777C_395E};
        vecs[2] = '{32'h0000_0000, 2'b00, 1'b1, 64'h0000_0000_0000_003F};
        vecs[3] = '{32'h0000_0000, 2'b00, 1'b0, 64'h3F3F_3F3F_3F3F_3F3F};
        vecs[4] = '{32'h89AB_CDEF, 2'b11, 1'b1, 64'h7F6F_777C_395E_7971};
        vecs[5] = '{32'h0123_4567, 2'b00, 1'b1, 64'h0006_5B4F_666D_7D07};
        vecs[6] = '{32'h0000_F000, 2'b01, 1'b1, 64'h0000_0000_713F_3F3F};
        vecs[7] = '{32'h0010_0000, 2'b10, 1'b1, 64'h3F3F_063F_3F3F_3F3F};

        rst = 1'b1; dif.load = 1'b0; dif.value = '0; dif.mode = 2'b00; dif.lz_blank = 1'b1;

        // Reset held two cycles, then release
        for (int n = 0; n < 2; n++) begin
            step();
            chk("reset_seg", dif.seg_out, {56{1'b1}});
            chk("reset_tick", dif.tick, 1'b0);
        end
        rst = 1'b0;
        step();
        chk("post_reset_lz1", dif.seg_out, from_pat(64'h0000_0000_0000_003F));
        chk("post_reset_tick", dif.tick, 1'b0);
        dif.lz_blank = 1'b0;
        step();
        chk("post_reset_lz0", dif.seg_out, from_pat(64'h3F3F_3F3F_3F3F_3F3F));

        // Vector table: result visible after the second edge
        for (int v = 0; v < 8; v++) begin
            do_load(vecs[v].value, vecs[v].mode, vecs[v].lz);
            step();
            chk($sformatf("vec%0d", v), dif.seg_out, from_pat(vecs[v].pat));
        end

        // Blink: tick every TD cycles, alternating dark / visible
        do_load(32'h8888_8888, 2'b01, 1'b0);
        for (int n = 1; n <= 12; n++) begin
            step();
            if (n == 4) chk("blink_tick", dif.tick, 1'b1);
            if (n == 3) chk("blink_notick", dif.tick, 1'b0);
            if (n == 5) chk("blink_dark", dif.seg_out, {56{1'b1}});
            if (n == 9) chk("blink_lit", dif.seg_out, from_pat(64'h7F7F_7F7F_7F7F_7F7F));
        end

        // Scroll: F walks up one digit per tick, wraps after ND ticks
        do_load(32'h0000_000F, 2'b10, 1'b0);
        for (int n = 1; n <= 33; n++) begin
            step();
            if (n == 1) chk("scroll_d0", dif.seg_out, from_pat(64'h3F3F_3F3F_3F3F_3F71));
            if (n == 5) chk("scroll_d1", dif.seg_out, from_pat(64'h3F3F_3F3F_3F3F_713F));
            if (n == 9) chk("scroll_d2", dif.seg_out, from_pat(64'h3F3F_3F3F_3F71_3F3F));
            if (n == 33) chk("scroll_wrap", dif.seg_out, from_pat(64'h3F3F_3F3F_3F3F_3F71));
        end

        // Load coinciding with a prescaler wrap
        for (int g = 0; g < 8 && m_cnt != TD - 1; g++) step();
        do_load(32'h0000_000F, 2'b10, 1'b0);
        chk("wrapload_notick", dif.tick, 1'b0);
        for (int n = 1; n <= 4; n++) begin
            step();
            if (n == 1) chk("wrapload_rot0", dif.seg_out, from_pat(64'h3F3F_3F3F_3F3F_3F71));
            if (n == 3) chk("wrapload_early", dif.tick, 1'b0);
            if (n == 4) chk("wrapload_tick", dif.tick, 1'b1);
        end

        // Reset together with load: value ignored
        rst = 1'b1; dif.load = 1'b1; dif.value = 32'hFFFF_FFFF; dif.mode = 2'b00;
        step();
        chk("rstload_dark", dif.seg_out, {56{1'b1}});
        rst = 1'b0; dif.load = 1'b0;
        step();
        chk("rstload_zero", dif.seg_out, from_pat(64'h3F3F_3F3F_3F3F_3F3F));

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            rst          = ($urandom % 200) == 0;
            dif.load     = ($urandom % 8) == 0;
            dif.value    = $urandom;
            if (($urandom % 16) == 0) dif.mode = 2'($urandom % 4);
            dif.lz_blank = 1'($urandom % 2);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
